// File: rtl/burst_capture_buf.sv
// Burst capture buffer: fills DEPTH samples, publishes their sum, then drains
// them oldest-first over a valid/ready stream. Fill and drain never overlap.
module burst_capture_buf #(
  parameter int DW    = 4,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int SW   = DW + AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [SW-1:0] burst_sum,
  output logic          sum_valid,
  output logic          drop,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   burst_sum_q, burst_sum_d;
  logic            sum_valid_q, sum_valid_d;
  logic            drop_q, drop_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   mem_d [DEPTH];

  logic handshake;

  // Outputs derive from the state flop so out_valid falls with async reset.
  assign out_valid = (state_q == DRAIN);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && (rd_ptr_q == PTR_LAST);
  assign handshake = out_valid && out_ready;
  assign burst_sum = burst_sum_q;
  assign sum_valid = sum_valid_q;
  assign drop      = drop_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    acc_d       = acc_q;
    burst_sum_d = burst_sum_q;
    sum_valid_d = 1'b0;
    drop_d      = 1'b0;
    mem_d       = mem_q;

    unique case (state_q)
      IDLE: begin
        drop_d = in_valid;
        if (enable) begin
          state_d  = FILL;
          wr_ptr_d = '0;
          acc_d    = '0;
        end
      end
      FILL: begin
        // Enable is checked first: a dropped enable aborts even with a sample present.
        if (!enable) begin
          drop_d   = in_valid;
          wr_ptr_d = '0;
          acc_d    = '0;
          state_d  = IDLE;
        end else if (in_valid) begin
          mem_d[wr_ptr_q] = in_data;
          wr_ptr_d        = wr_ptr_q + PTR_ONE;
          acc_d           = acc_q + SW'(in_data);
          if (wr_ptr_q == PTR_LAST) begin
            burst_sum_d = acc_q + SW'(in_data);
            sum_valid_d = 1'b1;
            rd_ptr_d    = '0;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        drop_d = in_valid;
        if (handshake) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          if (out_last) begin
            wr_ptr_d = '0;
            acc_d    = '0;
            state_d  = enable ? FILL : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      acc_q       <= '0;
      burst_sum_q <= '0;
      sum_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      acc_q       <= acc_d;
      burst_sum_q <= burst_sum_d;
      sum_valid_q <= sum_valid_d;
      drop_q      <= drop_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_burst_capture_buf.sv
// Scoreboard bench for burst_capture_buf: stimulus queues expected drain
// beats and sums; a negedge monitor pops and compares as the DUT emits them.
module tb_burst_capture_buf;

  logic       clk = 1'b0;
  logic       rstn;
  logic       enable;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic [6:0] burst_sum;
  logic       sum_valid;
  logic       drop;
  logic       busy;

  burst_capture_buf #(.DW(4), .DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .burst_sum(burst_sum),
    .sum_valid(sum_valid), .drop(drop), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       l;
  } beat_t;

  beat_t      exp_q[$];
  logic [6:0] sum_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         drop_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: handshakes, sum pulses, drop pulses and stall stability.
  initial begin
    logic       prev_stall = 1'b0;
    logic [3:0] prev_data  = '0;
    logic       prev_last  = 1'b0;
    beat_t      b;
    logic [6:0] s;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (out_valid && prev_stall) begin
          check("stall_data_stable", out_data, prev_data);
          check("stall_last_stable", out_last, prev_last);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            b = exp_q.pop_front();
            check("out_data", out_data, b.d);
            check("out_last", out_last, b.l);
          end
        end
        if (sum_valid) begin
          check("sum_with_out_valid", out_valid, 1);
          if (sum_q.size() == 0) begin
            check("unexpected_sum_valid", 1, 0);
          end else begin
            s = sum_q.pop_front();
            check("burst_sum", burst_sum, s);
          end
        end
        if (drop) drop_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  // Writes 8 samples on consecutive cycles; queues the first n_expect beats.
  task automatic fill(input logic [3:0] s [8], input int n_expect);
    int sum = 0;
    for (int i = 0; i < 8; i++) begin
      sum += s[i];
      if (i < n_expect) exp_q.push_back({s[i], (i == 7)});
    end
    sum_q.push_back(7'(sum));
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(output int n);
    n = 0;
    while (out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) check("drain_timeout", n, 8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_out_last"},  out_last, 0);
    check({tag, "_burst_sum"}, burst_sum, 0);
    check({tag, "_sum_valid"}, sum_valid, 0);
    check({tag, "_drop"},      drop, 0);
    check({tag, "_busy"},      busy, 0);
  endtask

  initial begin
    logic [3:0] ramp [8];
    logic [3:0] all15 [8];
    logic [3:0] all0 [8];
    logic [3:0] all2 [8];
    logic [3:0] mix [8];
    logic [3:0] rev [8];
    int n;

    for (int i = 0; i < 8; i++) begin
      ramp[i]  = 4'(i + 1);
      rev[i]   = 4'(8 - i);
      all15[i] = 4'd15;
      all0[i]  = 4'd0;
      all2[i]  = 4'd2;
    end
    mix = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6};

    rstn = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #23;
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    check("busy_after_enable", busy, 1);

    // Ramp burst, free-flowing drain
    fill(ramp, 8);
    wait_drain(n);
    check("drain_cycles", n, 8);
    check("refill_busy", busy, 1);
    check("refill_out_valid", out_valid, 0);
    check("no_drop_in_fill", drop_cnt, 0);

    // Max and zero bursts
    fill(all15, 8);
    wait_drain(n);
    fill(all0, 8);
    wait_drain(n);

    // Backpressure 1,0,0 pattern
    fill(ramp, 8);
    begin
      int k = 0;
      while (out_valid && k < 100) begin
        out_ready = (k % 3 == 0);
        @(posedge clk); #1;
        k++;
      end
      check("bp_cycles", k, 22);
    end
    out_ready = 1'b1;
    check("bp_all_drained", exp_q.size(), 0);

    // in_valid held through drain
    drop_cnt = 0;
    fill(rev, 8);
    in_valid = 1'b1; in_data = 4'd5;
    repeat (8) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("drain_done_after_8", out_valid, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("drops_in_drain", drop_cnt, 8);

    // Abort after 3 samples, then a clean burst of 2s
    drop_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'd7;
      @(posedge clk); #1;
    end
    enable = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_idle", busy, 0);
    enable = 1'b1;
    @(posedge clk); #1;
    check("reenable_busy", busy, 1);
    fill(all2, 8);
    wait_drain(n);
    repeat (2) begin @(posedge clk); #1; end
    check("abort_drop", drop_cnt, 1);

    // Reset after 4 handshakes mid-drain
    fill(ramp, 4);
    repeat (4) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    rstn = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", busy, 1);
    fill(mix, 8);
    wait_drain(n);
    repeat (2) begin @(posedge clk); #1; end
    check("beats_left", exp_q.size(), 0);
    check("sums_left", sum_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/burst_capture_buf.md
# burst_capture_buf

Capture buffer that collects a burst of DEPTH samples from the free-running sample counter stage, then drains them in order over a valid/ready stream. It sits directly downstream of the counter/sample generator and upstream of any stream consumer. It also reports the arithmetic sum of each captured burst. It alternates strictly between filling and draining, so it never reads and writes the same buffer in one cycle.

## Interface
- DW, 4, sample data width
- DEPTH, 8, entries per burst; power of two, >= 2
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- enable  in  1  permits a fill to start or continue
- in_valid  in  1  in_data holds a sample this cycle (no backpressure on input)
- in_data  in  DW  sample value
- out_valid  out  1  out_data holds a buffered sample
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  DW  buffered sample, oldest first
- out_last  out  1  out_data is entry DEPTH-1 of the burst
- burst_sum  out  DW+log2(DEPTH)  sum of the last completed burst
- sum_valid  out  1  one-cycle pulse when burst_sum updates
- drop  out  1  one-cycle pulse: in_valid sample was discarded
- busy  out  1  state != IDLE

## Operation
- States: IDLE, FILL, DRAIN. Pointers wr_ptr and rd_ptr are log2(DEPTH) bits. The accumulator acc is DW+log2(DEPTH) bits.
- IDLE:
  - enable=1 -> FILL next cycle. wr_ptr=0, acc=0.
  - in_valid in IDLE is discarded and pulses drop.
- FILL:
  - in_valid=1 -> buf[wr_ptr]<=in_data, wr_ptr+1, acc+=in_data.
  - On the write with wr_ptr==DEPTH-1:
    - burst_sum <= acc+in_data and sum_valid pulses.
    - State -> DRAIN and rd_ptr=0.
    - wr_ptr wraps to 0.
- FILL with enable=0 (checked before in_valid): partial burst aborted.
  - Sample that cycle not written and drop pulses if in_valid.
  - wr_ptr=0, acc=0, state -> IDLE.
  - burst_sum unchanged.
- DRAIN:
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==DEPTH-1).
  - Handshake = out_valid & out_ready. On a handshake rd_ptr increments.
  - On a handshake with out_last: enable=1 -> FILL, else -> IDLE.
  - in_valid in DRAIN is discarded and pulses drop. Enable changes have no effect in DRAIN.
- out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Sum never overflows: max DEPTH*(2^DW-1) fits DW+log2(DEPTH) bits. Additions are unsigned.

## Timing
- Reset (async assert, sync-safe deassert) values:
  - State IDLE; all pointers, acc and buffer entries 0.
  - out_valid=0, out_data=0, out_last=0.
  - burst_sum=0, sum_valid=0, drop=0, busy=0.
- enable rising in IDLE -> busy=1 next cycle. The first sample is accepted from that cycle on.
- Last fill write at edge N: out_valid=1 and sum_valid=1 in cycle N+1, with burst_sum valid from the same edge.
- Drain with out_ready held high: DEPTH consecutive cycles. out_last is in the DEPTH-th cycle.
- Back-to-back bursts: if enable=1, FILL begins the cycle after the final handshake. The minimum burst period is 2*DEPTH cycles.
- Reset mid-operation:
  - All state clears immediately.
  - out_valid drops asynchronously.
  - No partial sum is published.
- drop and sum_valid are registered single-cycle pulses. They can both assert in the same cycle only via distinct causes. drop never asserts for an accepted sample.

## Test plan
- Reset, enable=1, in_data 1..8 on consecutive cycles, out_ready=1 -> out_data 1,2,...,8 over 8 cycles; out_last only on 8; burst_sum=36 with one sum_valid pulse; then state FILL.
- All samples 15 -> burst_sum=120. Second burst of all 0 -> burst_sum=0. Checks the 7-bit width and that acc clears between bursts.
- Backpressure: fill 1..8, out_ready toggling 1,0,0,1,... -> out_data/out_last stable while stalled, order preserved, exactly 8 handshakes.
- in_valid held high through DRAIN -> drop pulses every DRAIN cycle; buffer contents and burst_sum unaffected.
- Abort: write 3 samples, drop enable -> IDLE, no sum_valid. Re-enable and write 8 samples of 2 -> burst_sum=16.
- rstn low for 1 ns mid-DRAIN (after 4 handshakes) -> out_valid=0 immediately, all outputs at reset values. Next fill restarts at entry 0.
